// File: rtl/piano_pkg.sv
// Shared definitions for the piano voice scheduler.
//   KEY_W             : width of a key index carried per voice
//   RANK_W            : width of a voice age rank (up to 4 voices)
//   DB_CYCLES_DEFAULT : default consecutive-sample count for key debounce
//   voice_state_e     : per-voice FSM state
//   voice_t           : per-voice state, note and age rank
package piano_pkg;

  localparam int KEY_W             = 3;
  localparam int RANK_W            = 2;
  localparam int DB_CYCLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    V_IDLE   = 2'd0,
    V_ACTIVE = 2'd1,
    V_GAP    = 2'd2
  } voice_state_e;

  typedef struct packed {
    voice_state_e        state;
    logic [KEY_W-1:0]    note;
    logic [RANK_W-1:0]   rank;  // 0 = youngest, NUM_VOICES-1 = oldest
  } voice_t;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer for one key.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   i_sw     : raw asynchronous switch
//   o_key_db : debounced key level; toggles once DB_CYCLES consecutive
//              synchronized samples disagree with it
module key_debounce
  import piano_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sw,
  output logic o_key_db
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge; blocking here would collapse the
  // synchronizer chain into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
        // This sample is the DB_CYCLES-th consecutive disagreement.
        r_db  <= ~r_db;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_key_db = r_db;

endmodule

// File: rtl/note_voice_sched.sv
// Polyphonic voice scheduler: debounces piano keys and assigns pressed keys
// to a small pool of voices, stealing the oldest sounding voice when full.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   sw         : raw piano switches, bit k = key k
//   lfsr_en    : bit k high iff some voice is ACTIVE on key k
//   voice_en   : bit v high iff voice v is ACTIVE
//   voice_note : key index per voice (voice v at bits 3v+2:3v), 0 unless ACTIVE
//   steal      : one-cycle pulse while a stolen voice sits in its gap cycle
module note_voice_sched
  import piano_pkg::*;
#(
  parameter int NUM_KEYS   = 8,
  parameter int NUM_VOICES = 2,
  parameter int DB_CYCLES  = DB_CYCLES_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_KEYS-1:0]         sw,
  output logic [NUM_KEYS-1:0]         lfsr_en,
  output logic [NUM_VOICES-1:0]       voice_en,
  output logic [NUM_VOICES*KEY_W-1:0] voice_note,
  output logic                        steal
);

  logic [NUM_KEYS-1:0]   w_key_db;
  logic [NUM_KEYS-1:0]   r_key_prev;
  logic [NUM_KEYS-1:0]   r_pending;
  logic                  r_steal;
  voice_t                r_voice     [NUM_VOICES];

  logic [NUM_KEYS-1:0]   w_rise;
  logic [NUM_KEYS-1:0]   w_fall;
  logic [2**KEY_W-1:0]   w_fall_x;
  logic [NUM_KEYS-1:0]   w_pend;
  logic [NUM_KEYS-1:0]   w_pend_nxt;
  logic [NUM_KEYS-1:0]   w_sel;
  logic [KEY_W-1:0]      w_key;
  logic                  w_found;
  voice_t                w_post      [NUM_VOICES];
  voice_t                w_voice_nxt [NUM_VOICES];
  logic                  w_have_idle;
  logic [RANK_W-1:0]     w_idle_v;
  logic [RANK_W-1:0]     w_idle_rank;
  logic                  w_have_old;
  logic [RANK_W-1:0]     w_old_v;
  logic [RANK_W-1:0]     w_old_rank;
  logic                  w_do;
  logic [RANK_W-1:0]     w_tgt;
  logic [RANK_W-1:0]     w_tgt_rank;
  logic                  w_steal;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk      (clk),
      .rst      (rst),
      .i_sw     (sw[k]),
      .o_key_db (w_key_db[k])
    );
  end

  // Next-state logic: release, then allocate, then advance gap voices.
  // NOTE: every signal written here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_rise   = w_key_db & ~r_key_prev;
    w_fall   = ~w_key_db & r_key_prev;
    w_fall_x = '0;
    w_fall_x[NUM_KEYS-1:0] = w_fall;
    // A rise is serviceable in the same cycle it is seen; a fall drops it.
    w_pend   = (r_pending | w_rise) & ~w_fall;

    // Lowest-indexed pending key.
    w_found = 1'b0;
    w_key   = '0;
    w_sel   = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (w_pend[k]) begin
        w_found  = 1'b1;
        w_key    = KEY_W'(k);
        w_sel    = '0;
        w_sel[k] = 1'b1;
      end
    end

    // Releases first so a freed voice is eligible this cycle; a gap voice
    // whose new key is already gone is released too.
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_post[v] = r_voice[v];
      if (r_voice[v].state != V_IDLE && w_fall_x[r_voice[v].note]) begin
        w_post[v].state = V_IDLE;
      end
    end

    w_have_idle = 1'b0;
    w_idle_v    = '0;
    w_idle_rank = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (w_post[v].state == V_IDLE) begin
        w_have_idle = 1'b1;
        w_idle_v    = RANK_W'(v);
        w_idle_rank = w_post[v].rank;
      end
    end

    // Oldest ACTIVE voice; gap voices are never candidates.
    w_have_old = 1'b0;
    w_old_v    = '0;
    w_old_rank = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (w_post[v].state == V_ACTIVE && (!w_have_old || w_post[v].rank > w_old_rank)) begin
        w_have_old = 1'b1;
        w_old_v    = RANK_W'(v);
        w_old_rank = w_post[v].rank;
      end
    end

    w_do       = 1'b0;
    w_steal    = 1'b0;
    w_tgt      = '0;
    w_tgt_rank = '0;
    if (w_found && w_have_idle) begin
      w_do       = 1'b1;
      w_tgt      = w_idle_v;
      w_tgt_rank = w_idle_rank;
    end else if (w_found && w_have_old) begin
      w_do       = 1'b1;
      w_steal    = 1'b1;
      w_tgt      = w_old_v;
      w_tgt_rank = w_old_rank;
    end

    // Unserviced pending bits are held, not dropped.
    w_pend_nxt = w_do ? (w_pend & ~w_sel) : w_pend;

    for (int v = 0; v < NUM_VOICES; v++) begin
      w_voice_nxt[v] = w_post[v];
      if (w_post[v].state == V_GAP) begin
        w_voice_nxt[v].state = V_ACTIVE;
      end
      if (w_do) begin
        if (RANK_W'(v) == w_tgt) begin
          w_voice_nxt[v].state = w_steal ? V_GAP : V_ACTIVE;
          w_voice_nxt[v].note  = w_key;
          w_voice_nxt[v].rank  = '0;
        end else if (w_post[v].rank < w_tgt_rank) begin
          // Only voices younger than the target age, keeping a permutation.
          w_voice_nxt[v].rank = w_post[v].rank + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_prev <= '0;
      r_pending  <= '0;
      r_steal    <= 1'b0;
      // NOTE: the voice table is a handful of flops, not a RAM, so it is reset
      // element by element; ranks restart as the identity permutation.
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_voice[v].state <= V_IDLE;
        r_voice[v].note  <= '0;
        r_voice[v].rank  <= RANK_W'(v);
      end
    end else begin
      r_key_prev <= w_key_db;
      r_pending  <= w_pend_nxt;
      r_steal    <= w_steal;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_voice[v] <= w_voice_nxt[v];
      end
    end
  end

  // Outputs are decoded straight from registered voice state.
  always_comb begin
    lfsr_en    = '0;
    voice_en   = '0;
    voice_note = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (r_voice[v].state == V_ACTIVE) begin
        voice_en[v]                    = 1'b1;
        voice_note[v*KEY_W +: KEY_W]   = r_voice[v].note;
        for (int k = 0; k < NUM_KEYS; k++) begin
          if (r_voice[v].note == KEY_W'(k)) lfsr_en[k] = 1'b1;
        end
      end
    end
  end

  assign steal = r_steal;

endmodule

// File: tb/tb_note_voice_sched.sv
// Directed self-checking bench for note_voice_sched (DB_CYCLES=4, 2 voices).
// A raw switch change reaches key_db 6 edges later (2 sync + 4 samples) and
// voice_en one edge after that.
module tb_note_voice_sched;

  logic       clk;
  logic       rst;
  logic [7:0] sw;
  logic [7:0] lfsr_en;
  logic [1:0] voice_en;
  logic [5:0] voice_note;
  logic       steal;

  int total = 0;
  int bad   = 0;

  note_voice_sched #(
    .NUM_KEYS   (8),
    .NUM_VOICES (2),
    .DB_CYCLES  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .lfsr_en    (lfsr_en),
    .voice_en   (voice_en),
    .voice_note (voice_note),
    .steal      (steal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_lfsr,
                           input logic [1:0] e_ven, input logic [5:0] e_note,
                           input logic e_steal);
    check({tag, ".lfsr_en"},    32'(lfsr_en),    32'(e_lfsr));
    check({tag, ".voice_en"},   32'(voice_en),   32'(e_ven));
    check({tag, ".voice_note"}, 32'(voice_note), 32'(e_note));
    check({tag, ".steal"},      32'(steal),      32'(e_steal));
  endtask

  initial begin
    rst = 1'b1;
    sw  = 8'h00;
    tick(2);
    check_all("reset", 8'h00, 2'b00, 6'd0, 1'b0);
    rst = 1'b0;
    tick(1);
    check_all("post_reset", 8'h00, 2'b00, 6'd0, 1'b0);

    // Case 1: three-cycle glitch on key 3 never debounces.
    sw = 8'h08;
    tick(3);
    sw = 8'h00;
    for (int i = 0; i < 10; i++) begin
      check("glitch.lfsr_en", 32'(lfsr_en), 32'h0);
    end
    check("glitch.voice_en", 32'(voice_en), 32'h0);

    // Case 2: key 2 held, then released; exact latency both ways.
    sw = 8'h04;
    tick(6);
    check("k2.before_en", 32'(voice_en), 32'h0);
    tick(1);
    check_all("k2.on", 8'h04, 2'b01, 6'd2, 1'b0);
    sw = 8'h00;
    tick(6);
    check("k2.hold_en", 32'(voice_en), 32'h1);
    tick(1);
    check_all("k2.off", 8'h00, 2'b00, 6'd0, 1'b0);

    // Case 3: keys 1 and 5 together, serviced one per cycle.
    sw = 8'h22;
    tick(7);
    check_all("k15.first", 8'h02, 2'b01, 6'd1, 1'b0);
    tick(1);
    check_all("k15.second", 8'h22, 2'b11, 6'd41, 1'b0);
    sw = 8'h00;
    tick(7);
    check_all("k15.off", 8'h00, 2'b00, 6'd0, 1'b0);

    // Case 4: keys 0,4 held, key 7 steals the oldest voice (voice 0).
    sw = 8'h11;
    tick(8);
    check_all("k04.on", 8'h11, 2'b11, 6'd32, 1'b0);
    sw = 8'h91;
    tick(7);
    check_all("k7.gap", 8'h10, 2'b10, 6'd32, 1'b1);
    tick(1);
    check_all("k7.active", 8'h90, 2'b11, 6'd39, 1'b0);
    sw = 8'h00;
    tick(7);
    check_all("k047.off", 8'h00, 2'b00, 6'd0, 1'b0);

    // Case 5: key 6 on voice 1 released as key 2 is serviced.
    sw = 8'h41;
    tick(8);
    check_all("k06.on", 8'h41, 2'b11, 6'd48, 1'b0);
    sw = 8'h05;
    tick(6);
    check("k2swap.before", 32'(lfsr_en), 32'h41);
    tick(1);
    check_all("k2swap.after", 8'h05, 2'b11, 6'd16, 1'b0);
    tick(1);
    check("k2swap.steal_next", 32'(steal), 32'h0);

    // Case 6: key 3 steals voice 0, reset lands during the gap.
    sw = 8'h0D;
    tick(6);
    tick(1);
    check_all("k3.gap", 8'h04, 2'b10, 6'd16, 1'b1);
    rst = 1'b1;
    sw  = 8'h00;
    tick(1);
    check_all("gap_rst", 8'h00, 2'b00, 6'd0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("after_rst.voice_en", 32'(voice_en), 32'h0);
      check("after_rst.steal",    32'(steal),    32'h0);
      tick(1);
    end
    check("after_rst.lfsr_en", 32'(lfsr_en), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
